// File: rtl/transformer_pkg.sv
// Shared definitions for the transformer datapath blocks.
//   FRAC_BITS    : fractional bits of the Q8.8 element format
//   Q_MAX/Q_MIN  : Q8.8 saturation bounds
//   state_t      : layer-norm sequencer state encoding
package transformer_pkg;

  localparam int unsigned FRAC_BITS = 8;
  localparam int          Q_MAX     = 32767;
  localparam int          Q_MIN     = -32768;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUM  = 3'd1,
    ST_VAR  = 3'd2,
    ST_SQRT = 3'd3,
    ST_DIV  = 3'd4,
    ST_NORM = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/seq_isqrt.sv
// Sequential restoring integer square root, one root bit per cycle.
//   clk, rst_n : clock, async active-low reset
//   i_start    : load i_rad and perform the first iteration this cycle
//   i_rad      : radicand (RAD_W bits, even)
//   o_root     : floor(sqrt(i_rad)), valid once o_busy falls
//   o_busy     : iterations in progress
//   o_done_c   : high during the cycle of the final iteration
module seq_isqrt #(
  parameter int unsigned RAD_W = 34
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [RAD_W-1:0]     i_rad,
  output logic [RAD_W/2-1:0]   o_root,
  output logic                 o_busy,
  output logic                 o_done_c
);

  localparam int unsigned ROOT_W = RAD_W / 2;
  localparam int unsigned REM_W  = ROOT_W + 3;
  localparam int unsigned CNT_W  = $clog2(ROOT_W) + 1;

  logic [RAD_W-1:0]  r_rad;
  logic [REM_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_cnt;

  logic [RAD_W-1:0]  w_rad;
  logic [REM_W-1:0]  w_rem_src;
  logic [REM_W-1:0]  w_rem_sh;
  logic [REM_W-1:0]  w_trial;
  logic [ROOT_W-1:0] w_root_src;
  logic              w_ge;

  // Start cycle iterates directly on the incoming radicand so the root takes ROOT_W cycles total
  always_comb begin
    w_rad      = i_start ? i_rad : r_rad;
    w_rem_src  = i_start ? '0 : r_rem;
    w_root_src = i_start ? '0 : o_root;
    w_rem_sh   = REM_W'({w_rem_src, w_rad[RAD_W-1 -: 2]});
    w_trial    = REM_W'({w_root_src, 2'b01});
    w_ge       = (w_rem_sh >= w_trial);
    o_done_c   = o_busy && (r_cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      o_root <= '0;
      o_busy <= 1'b0;
    end else if (i_start || o_busy) begin
      r_rad  <= w_rad << 2;
      r_rem  <= w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
      o_root <= ROOT_W'({w_root_src, w_ge});
      if (i_start) begin
        r_cnt  <= CNT_W'(ROOT_W - 1);
        o_busy <= 1'b1;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) o_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/layer_norm_seq.sv
// Sequential layer normalisation of one Q8.8 vector:
//   y = sat16(((((x - mean) * floor(65536/isqrt(var+EPS))) >>> 8) * gamma >>> 8) + beta)
//   clk, rst_n            : clock, async active-low reset
//   valid_in / ready_out  : vector accepted when both high (ready only in IDLE)
//   x_in, gamma_flat, beta_flat : packed element vectors, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   y_out / valid_out     : result vector, held until next result; one-cycle valid pulse
module layer_norm_seq
  import transformer_pkg::*;
#(
  parameter int unsigned EMBED_DIM  = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned EPS        = 66
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_in,
  output logic                            ready_out,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0] x_in,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0] gamma_flat,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0] beta_flat,
  output logic [EMBED_DIM*DATA_WIDTH-1:0] y_out,
  output logic                            valid_out
);

  localparam int unsigned LOG2N   = $clog2(EMBED_DIM);
  localparam int unsigned VEC_W   = EMBED_DIM * DATA_WIDTH;
  localparam int unsigned SUM_W   = DATA_WIDTH + LOG2N;
  localparam int unsigned D_W     = DATA_WIDTH + 1;
  localparam int unsigned SQ_W    = 2 * D_W;
  localparam int unsigned SQACC_W = SQ_W + LOG2N;
  localparam int unsigned RAD_W   = SQ_W;
  localparam int unsigned ROOT_W  = RAD_W / 2;
  localparam int unsigned QUO_W   = 2 * FRAC_BITS + 1;
  localparam int unsigned T_W     = SQ_W - FRAC_BITS;
  localparam int unsigned P_W     = T_W + DATA_WIDTH;
  localparam int unsigned Y_W     = P_W - FRAC_BITS + 1;
  localparam int unsigned CNT_W   = ((LOG2N > 5) ? LOG2N : 5) + 1;

  state_t                     r_state, w_next;
  logic [CNT_W-1:0]           r_cnt;
  logic [VEC_W-1:0]           r_x, r_g, r_b, r_y_stage;
  logic signed [SUM_W-1:0]    r_sum;
  logic [SQACC_W-1:0]         r_sq_acc;
  logic [ROOT_W-1:0]          r_rem;
  logic [QUO_W-1:0]           r_dvd, r_quo;

  logic [LOG2N-1:0]           w_idx;
  logic signed [DATA_WIDTH-1:0] w_x_elem, w_g_elem, w_b_elem, w_mean, w_y_sat;
  logic signed [D_W-1:0]      w_d;
  logic signed [SQ_W-1:0]     w_d_ext, w_d_sq, w_inv_ext, w_prod1;
  logic signed [T_W-1:0]      w_t;
  logic signed [P_W-1:0]      w_prod2;
  logic signed [Y_W-1:0]      w_scaled, w_ysum;
  logic [RAD_W-1:0]           w_rad;
  logic [ROOT_W-1:0]          w_std;
  logic [ROOT_W:0]            w_div_sh, w_std_ext;
  logic                       w_ge, w_sqrt_busy, w_sqrt_done_c, w_sqrt_start, w_last_elem;

  // Element datapath shared by SUM/VAR/NORM, indexed by the phase counter
  always_comb begin
    w_idx     = r_cnt[LOG2N-1:0];
    w_x_elem  = $signed(r_x[w_idx*DATA_WIDTH +: DATA_WIDTH]);
    w_g_elem  = $signed(r_g[w_idx*DATA_WIDTH +: DATA_WIDTH]);
    w_b_elem  = $signed(r_b[w_idx*DATA_WIDTH +: DATA_WIDTH]);
    w_mean    = DATA_WIDTH'(r_sum >>> LOG2N);
    w_d       = D_W'(w_x_elem) - D_W'(w_mean);
    w_d_ext   = SQ_W'(w_d);
    w_d_sq    = w_d_ext * w_d_ext;
    w_rad     = RAD_W'(r_sq_acc >> LOG2N) + RAD_W'(EPS);
    w_std_ext = (ROOT_W+1)'(w_std);
    w_div_sh  = {r_rem, r_dvd[QUO_W-1]};
    w_ge      = (w_div_sh >= w_std_ext);
    w_inv_ext = (r_quo > QUO_W'(Q_MAX)) ? SQ_W'(Q_MAX) : SQ_W'(r_quo);
    w_prod1   = w_d_ext * w_inv_ext;
    w_t       = T_W'(w_prod1 >>> FRAC_BITS);
    w_prod2   = P_W'(w_t) * P_W'(w_g_elem);
    w_scaled  = Y_W'(w_prod2 >>> FRAC_BITS);
    w_ysum    = w_scaled + Y_W'(w_b_elem);
    if (w_ysum > Y_W'(Q_MAX))      w_y_sat = DATA_WIDTH'(Q_MAX);
    else if (w_ysum < Y_W'(Q_MIN)) w_y_sat = DATA_WIDTH'(Q_MIN);
    else                           w_y_sat = DATA_WIDTH'(w_ysum);
  end

  assign w_sqrt_start = (r_state == ST_SQRT) && !w_sqrt_busy;

  seq_isqrt #(.RAD_W(RAD_W)) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_sqrt_start),
    .i_rad    (w_rad),
    .o_root   (w_std),
    .o_busy   (w_sqrt_busy),
    .o_done_c (w_sqrt_done_c)
  );

  // Next-state logic
  always_comb begin
    w_next      = r_state;
    w_last_elem = (r_cnt == CNT_W'(EMBED_DIM - 1));
    case (r_state)
      ST_IDLE: if (valid_in)      w_next = ST_SUM;
      ST_SUM:  if (w_last_elem)   w_next = ST_VAR;
      ST_VAR:  if (w_last_elem)   w_next = ST_SQRT;
      ST_SQRT: if (w_sqrt_done_c) w_next = ST_DIV;
      ST_DIV:  if (r_cnt == CNT_W'(QUO_W - 1)) w_next = ST_NORM;
      ST_NORM: if (w_last_elem)   w_next = ST_DONE;
      ST_DONE:                    w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_x       <= '0;
      r_g       <= '0;
      r_b       <= '0;
      r_y_stage <= '0;
      r_sum     <= '0;
      r_sq_acc  <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_quo     <= '0;
      y_out     <= '0;
      valid_out <= 1'b0;
      ready_out <= 1'b1;
    end else begin
      r_state   <= w_next;
      ready_out <= (w_next == ST_IDLE);
      valid_out <= 1'b0;
      r_cnt     <= ((w_next != r_state) || (r_state == ST_IDLE)) ? '0 : r_cnt + CNT_W'(1);
      case (r_state)
        ST_IDLE: if (valid_in) begin
          r_x      <= x_in;
          r_g      <= gamma_flat;
          r_b      <= beta_flat;
          r_sum    <= '0;
          r_sq_acc <= '0;
        end
        ST_SUM:  r_sum    <= r_sum + SUM_W'(w_x_elem);
        ST_VAR:  r_sq_acc <= r_sq_acc + SQACC_W'($unsigned(w_d_sq));
        // Divider dividend is 1.0 in Q16.16, shifted out MSB first
        ST_SQRT: if (w_sqrt_done_c) begin
          r_rem <= '0;
          r_dvd <= QUO_W'(1) << (2 * FRAC_BITS);
          r_quo <= '0;
        end
        ST_DIV: begin
          r_rem <= w_ge ? ROOT_W'(w_div_sh - w_std_ext) : ROOT_W'(w_div_sh);
          r_quo <= QUO_W'({r_quo, w_ge});
          r_dvd <= r_dvd << 1;
        end
        ST_NORM: r_y_stage[w_idx*DATA_WIDTH +: DATA_WIDTH] <= w_y_sat;
        ST_DONE: begin
          y_out     <= r_y_stage;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/layer_norm_seq.md
LAYER_NORM_SEQ -- requirements
Module: layer_norm_seq

Interface
REQ-001 SHALL have parameter EMBED_DIM, default 4, vector length; a power of two, minimum 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, signed Q8.8 element width.
REQ-003 SHALL have parameter EPS, default 66, variance epsilon in Q16.16 (about 0.001).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port valid_in  input  1  x_in/gamma_flat/beta_flat valid this cycle.
REQ-007 SHALL have port ready_out  output  1  high only in IDLE; the block accepts a vector only when ready_out is high.
REQ-008 SHALL have port x_in  input  EMBED_DIM*DATA_WIDTH  input vector; element i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port gamma_flat  input  EMBED_DIM*DATA_WIDTH  per-element Q8.8 scale.
REQ-010 SHALL have port beta_flat  input  EMBED_DIM*DATA_WIDTH  per-element Q8.8 shift.
REQ-011 SHALL have port y_out  output  EMBED_DIM*DATA_WIDTH  normalised vector; feeds ffn_block x_in directly.
REQ-012 SHALL have port valid_out  output  1  one-cycle pulse when y_out is updated.

Function
REQ-013 SHALL implement the FSM IDLE -> SUM -> VAR -> SQRT -> DIV -> NORM -> DONE -> IDLE.
REQ-014 SHALL, in IDLE with valid_in high, register x_in, gamma_flat and beta_flat and enter SUM; valid_in in any other state SHALL be ignored.
REQ-015 SHALL run SUM for EMBED_DIM cycles, accumulating one element per cycle into an accumulator of DATA_WIDTH+log2(EMBED_DIM) bits; mean = sum >>> log2(EMBED_DIM), arithmetic, floor.
REQ-016 SHALL run VAR for EMBED_DIM cycles, computing d = x - mean (17 bits) and accumulating d*d (Q16.16); var = acc >> log2(EMBED_DIM).
REQ-017 SHALL run SQRT for exactly 17 cycles: restoring bitwise integer square root of (var + EPS), one result bit per cycle, giving std in Q8.8.
REQ-018 SHALL run DIV for exactly 17 cycles: restoring division inv = floor(65536 / std), one quotient bit per cycle; inv > 32767 SHALL saturate to 32767.
REQ-019 SHALL run NORM for EMBED_DIM cycles, one element per cycle: t = (d*inv) >>> 8; y = sat16(((t*gamma) >>> 8) + beta); intermediates SHALL be wide enough that no overflow occurs before the final saturation.
REQ-020 SHALL saturate results to [-32768, 32767].
REQ-021 SHALL, in DONE, drive the complete y_out and pulse valid_out for one cycle, then return to IDLE; fixed latency of 3*EMBED_DIM+35 rising edges from the accepting edge to the edge that raises valid_out (47 for EMBED_DIM=4).
REQ-022 SHALL hold y_out stable from DONE until the next DONE.
REQ-023 SHALL, when all elements are equal, give var=0 and std=isqrt(EPS), and y SHALL equal beta exactly because d=0.
REQ-024 SHALL allow a new vector to be accepted on the first IDLE cycle after DONE; no back-to-back overlap.

Reset
REQ-025 SHALL, on rst_n low, immediately clear the state to IDLE, y_out=0, valid_out=0, ready_out=1, and all accumulators and counters to 0.
REQ-026 SHALL, when reset is asserted mid-operation, abandon the in-flight vector with no valid_out and no partial y_out update.

Structure
REQ-027 SHALL place FRAC_BITS=8, the Q8.8 saturation bounds and the FSM state encoding in the shared package transformer_pkg.
REQ-028 SHALL implement the 17-cycle square root as sub-module seq_isqrt (start/done handshake); the divider SHALL stay inline.

Verification
REQ-029 SHALL cover: x=[1.0,-1.0,1.0,-1.0] (256,-256,256,-256), gamma=1.0, beta=0 -> y within ±2 LSB of [255,-255,255,-255], valid_out at edge 47.
REQ-030 SHALL cover: x all 3.0, gamma=2.0, beta=0.5 -> y exactly [128,128,128,128].
REQ-031 SHALL cover: x=[0,0,0,2048], gamma=127.0, beta=127.0 -> element 3 saturates to 32767.
REQ-032 SHALL cover: valid_in held high during busy, with a second vector presented -> only the first vector is processed, one valid_out, ready_out low throughout.
REQ-033 SHALL cover: rst_n pulsed low during SQRT -> no valid_out, y_out=0, ready_out=1; a fresh vector afterwards completes in 47 cycles.
REQ-034 SHALL cover: chained into ffn_block with the identity weights from the FFN test -> FFN valid_out follows within its own latency and the values match the Python model.
